vga_fb_arbiter: RTL

- Shares one single-port frame-buffer memory between VGA scanout reads and a drawing-engine writer.
- Prefetches pixels in raster order into a small FIFO. Pixels are popped on the VGA controller's pixel-request strobe.
- Drawing writes are granted whenever the prefetch FIFO is comfortably full, or when the frame fetch is complete.
- Sits between the VGA timing controller, the drawing engine and the SRAM/on-chip frame buffer.

---
 rtl/vga_fb_arbiter_if.sv | 27 ++
 rtl/vga_fb_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter_if.sv
// Frame-buffer memory port: registered command out of the arbiter, read data back
// from the memory after a fixed latency.
interface vga_fb_arbiter_if #(
   parameter int ADDR_W = 19
) ();
   logic [ADDR_W-1:0] oMemAddr;
   logic [23:0]       oMemWrData;
   logic              oMemWE;
   logic              oMemRE;
   logic [23:0]       iMemRdData;

   modport master (
      output oMemAddr,
      output oMemWrData,
      output oMemWE,
      output oMemRE,
      input  iMemRdData
   );

   modport slave (
      input  oMemAddr,
      input  oMemWrData,
      input  oMemWE,
      input  oMemRE,
      output iMemRdData
   );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: raster-order prefetch into a small FIFO for VGA
// scanout, with drawing-engine writes slotted in whenever the prefetch can afford it.
module vga_fb_arbiter #(
   parameter int ADDR_W     = 19,
   parameter int H_ACT      = 640,
   parameter int V_ACT      = 480,
   parameter int FIFO_DEPTH = 8,
   parameter int WR_THRESH  = 6,
   parameter int MEM_LAT    = 2
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic              iFrameStart,
   input  logic              iPixReq,
   output logic [23:0]       oPixel,
   output logic              oUnderflow,
   input  logic              iWrReq,
   input  logic [ADDR_W-1:0] iWrAddr,
   input  logic [23:0]       iWrData,
   output logic              oWrAck,
   vga_fb_arbiter_if.master  mem_if
);
   localparam int CW          = $clog2(FIFO_DEPTH) + 1;
   localparam int PW          = $clog2(FIFO_DEPTH);
   localparam int FRAME_WORDS = H_ACT * V_ACT;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [CW-1:0]     inflight, used;
   logic [MEM_LAT-1:0] vld_q, vld_d;
   logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
   logic [23:0]       fifo_q [FIFO_DEPTH];
   logic [23:0]       pix_q, pix_d;
   logic              undf_q, undf_d;
   logic [ADDR_W-1:0] maddr_q, maddr_d;
   logic [23:0]       mwdata_q, mwdata_d;
   logic              mwe_q, mre_q;
   logic              rd_elig, wr_elig, rd_gnt, wr_gnt, push, pop;

   // Reads already committed (on the port or in the return pipe) reserve FIFO room.
   always_comb begin
      inflight = CW'(mre_q);
      for (int i = 0; i < MEM_LAT; i++) begin
         inflight = inflight + CW'(vld_q[i]);
      end
      used = count_q + inflight;
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no latch is inferred.
      state_d  = state_q;
      raddr_d  = raddr_q;
      maddr_d  = maddr_q;
      mwdata_d = mwdata_q;
      rd_gnt   = 1'b0;
      wr_gnt   = 1'b0;

      // No read is issued in a restart cycle: it would target the old frame address.
      rd_elig = (state_q == S_FETCH) && (used < CW'(FIFO_DEPTH)) && !iFrameStart;
      wr_elig = iWrReq && !mwe_q;

      if (rd_elig && (used < CW'(WR_THRESH))) begin
         rd_gnt = 1'b1;
      end else if (wr_elig) begin
         wr_gnt = 1'b1;
      end else if (rd_elig) begin
         rd_gnt = 1'b1;
      end

      if (rd_gnt) begin
         maddr_d = raddr_q;
         raddr_d = raddr_q + ADDR_W'(1);
         if (raddr_q == LAST_ADDR) begin
            state_d = S_DONE;
         end
      end else if (wr_gnt) begin
         maddr_d  = iWrAddr;
         mwdata_d = iWrData;
      end

      if (iFrameStart) begin
         state_d = S_FETCH;
         raddr_d = '0;
      end
   end

   // Read-return pipe and FIFO bookkeeping; a restart discards everything in flight.
   always_comb begin
      push = vld_q[MEM_LAT-1] && !iFrameStart;
      pop  = iPixReq && (count_q != '0);

      vld_d    = '0;
      vld_d[0] = mre_q;
      for (int i = 1; i < MEM_LAT; i++) begin
         vld_d[i] = vld_q[i-1];
      end

      count_d = count_q + CW'(push) - CW'(pop);
      wptr_d  = wptr_q + PW'(push);
      rptr_d  = rptr_q + PW'(pop);

      pix_d  = pix_q;
      undf_d = undf_q;
      if (iPixReq) begin
         pix_d = pop ? fifo_q[rptr_q] : 24'h0;
         if (!pop) begin
            undf_d = 1'b1;
         end
      end

      if (iFrameStart) begin
         vld_d   = '0;
         count_d = '0;
         wptr_d  = '0;
         rptr_d  = '0;
         undf_d  = 1'b0;
      end
   end

   always_ff @(posedge iCLK) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!iRST_N) begin
         state_q  <= S_IDLE;
         raddr_q  <= '0;
         count_q  <= '0;
         vld_q    <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         pix_q    <= '0;
         undf_q   <= 1'b0;
         maddr_q  <= '0;
         mwdata_q <= '0;
         mwe_q    <= 1'b0;
         mre_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         raddr_q  <= raddr_d;
         count_q  <= count_d;
         vld_q    <= vld_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         pix_q    <= pix_d;
         undf_q   <= undf_d;
         maddr_q  <= maddr_d;
         mwdata_q <= mwdata_d;
         mwe_q    <= wr_gnt;
         mre_q    <= rd_gnt;
      end
   end

   // NOTE: FIFO storage is not reset; count and pointers alone decide what is valid.
   always_ff @(posedge iCLK) begin
      if (push) begin
         fifo_q[wptr_q] <= mem_if.iMemRdData;
      end
   end

   assign oPixel            = pix_q;
   assign oUnderflow        = undf_q;
   assign oWrAck            = mwe_q;
   assign mem_if.oMemAddr   = maddr_q;
   assign mem_if.oMemWrData = mwdata_q;
   assign mem_if.oMemWE     = mwe_q;
   assign mem_if.oMemRE     = mre_q;

endmodule
